// File: rtl/trigger_capture_pkg.sv
// trigger_capture_pkg: shared types and sizing for the trigger capture slice.
//   state_e   - capture FSM states
//   depth()   - buffer depth N = 2^addr_w
//   TC_N      - depth for the default address width
package trigger_capture_pkg;

   localparam int unsigned TC_DATA_W = 8;
   localparam int unsigned TC_ADDR_W = 4;
   localparam int unsigned TC_N      = 32'd1 << TC_ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } state_e;

   // Circular buffer depth for a given address width.
   function automatic int unsigned depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: sample stream, trigger configuration, buffer write port
// and status of the capture stage.
//   slave  - capture block: takes arm/samples/config, drives writes/status
//   master - controller/ADC side: the opposite directions
interface trigger_capture_if #(
   parameter int unsigned DATA_W = trigger_capture_pkg::TC_DATA_W,
   parameter int unsigned ADDR_W = trigger_capture_pkg::TC_ADDR_W
);
   logic              arm;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_in;
   logic [DATA_W-1:0] trig_level;
   logic              trig_rising;
   logic [ADDR_W-1:0] pretrig;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] trig_addr;
   logic              busy;
   logic              done;

   modport slave (
      input  arm, sample_valid, sample_in, trig_level, trig_rising, pretrig,
      output wr_en, wr_addr, wr_data, trig_addr, busy, done
   );

   modport master (
      output arm, sample_valid, sample_in, trig_level, trig_rising, pretrig,
      input  wr_en, wr_addr, wr_data, trig_addr, busy, done
   );
endinterface

// File: rtl/trigger_capture_edge_detect.sv
// trigger_capture_edge_detect: combinational level-crossing detector.
//   prev, sample - previous and current accepted samples
//   level        - threshold (unsigned)
//   rising       - 1: crossing upward, 0: crossing downward
//   hit_c        - crossing detected this cycle
module trigger_capture_edge_detect
   import trigger_capture_pkg::*;
#(
   parameter int unsigned DATA_W = TC_DATA_W
) (
   input  logic [DATA_W-1:0] prev,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] level,
   input  logic              rising,
   output logic              hit_c
);
   always_comb begin
      if (rising) hit_c = (prev <  level) && (sample >= level);
      else        hit_c = (prev >= level) && (sample <  level);
   end
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: oscilloscope acquisition front stage. Writes the sample
// stream into a circular buffer, keeping `pretrig` samples ahead of the trigger
// and filling the rest of the buffer after it.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus (slave)  - arm, samples and trigger config in; buffer write port,
//                  trigger address, busy and done out (all registered)
module trigger_capture
   import trigger_capture_pkg::*;
#(
   parameter int unsigned DATA_W = TC_DATA_W,
   parameter int unsigned ADDR_W = TC_ADDR_W
) (
   input  logic             clock,
   input  logic             reset,
   trigger_capture_if.slave bus
);
   localparam int unsigned N = depth(ADDR_W);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] pretrig_q, pretrig_d;
   logic [DATA_W-1:0] level_q, level_d;
   logic              rising_q, rising_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              prev_valid_q, prev_valid_d;
   logic              wr_en_d, busy_d, done_d;
   logic [ADDR_W-1:0] wr_addr_d, trig_addr_d;
   logic [DATA_W-1:0] wr_data_d;
   logic              accept_c;
   logic              hit_c;

   assign accept_c = bus.sample_valid && (state_q inside {ST_PRE, ST_WAIT, ST_POST});

   trigger_capture_edge_detect #(.DATA_W(DATA_W)) edge_detect (
      .prev   (prev_q),
      .sample (bus.sample_in),
      .level  (level_q),
      .rising (rising_q),
      .hit_c  (hit_c)
   );

   // Next state, counters and registered-output next values.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      pretrig_d    = pretrig_q;
      level_d      = level_q;
      rising_d     = rising_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = bus.wr_addr;
      wr_data_d    = bus.wr_data;
      trig_addr_d  = bus.trig_addr;

      if (accept_c) begin
         wr_en_d      = 1'b1;
         wr_addr_d    = ptr_q;
         wr_data_d    = bus.sample_in;
         ptr_d        = ptr_q + ADDR_W'(1);
         prev_d       = bus.sample_in;
         prev_valid_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.arm) begin
               state_d      = ST_PRE;
               ptr_d        = '0;
               cnt_d        = '0;
               prev_valid_d = 1'b0;
               pretrig_d    = bus.pretrig;
               level_d      = bus.trig_level;
               rising_d     = bus.trig_rising;
            end
         end
         ST_PRE: begin
            // Zero pre-trigger depth leaves PRE at once; a sample arriving then
            // is still written, it only seeds prev.
            if (pretrig_q == '0) begin
               state_d = ST_WAIT;
            end else if (accept_c) begin
               cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_d == pretrig_q) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (accept_c && prev_valid_q && hit_c) begin
               trig_addr_d = ptr_q;
               cnt_d       = ADDR_W'(N - 1) - pretrig_q;
               state_d     = (cnt_d == '0) ? ST_DONE : ST_POST;
            end
         end
         ST_POST: begin
            if (accept_c) begin
               cnt_d = cnt_q - ADDR_W'(1);
               if (cnt_d == '0) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // busy stays up through the final write; done follows one cycle later.
      busy_d = (state_d inside {ST_PRE, ST_WAIT, ST_POST}) ||
               ((state_d == ST_DONE) && (state_q != ST_DONE));
      done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         pretrig_q     <= '0;
         level_q       <= '0;
         rising_q      <= 1'b0;
         prev_q        <= '0;
         prev_valid_q  <= 1'b0;
         bus.wr_en     <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
         bus.trig_addr <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         pretrig_q     <= pretrig_d;
         level_q       <= level_d;
         rising_q      <= rising_d;
         prev_q        <= prev_d;
         prev_valid_q  <= prev_valid_d;
         bus.wr_en     <= wr_en_d;
         bus.wr_addr   <= wr_addr_d;
         bus.wr_data   <= wr_data_d;
         bus.trig_addr <= trig_addr_d;
         bus.busy      <= busy_d;
         bus.done      <= done_d;
      end
   end
endmodule

// File: doc/trigger_capture.md
# trigger_capture

Oscilloscope acquisition front stage: accepts the ADC sample stream, performs level/edge trigger detection with programmable pre-trigger depth, and generates write strobes, addresses and data for the circular sample buffer. The block sits between the ADC interface and the sample memory. It reports the trigger position and capture completion to the readout/control logic.

## Interface
- `DATA_W`, 8, sample width in bits (unsigned).
- `ADDR_W`, 4, buffer address width; depth N = 2^ADDR_W.

- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `arm`  in  1  one-cycle pulse; starts a capture from IDLE or DONE.
- `sample_valid`  in  1  `sample_in` carries a new sample this cycle.
- `sample_in`  in  DATA_W  ADC sample.
- `trig_level`  in  DATA_W  trigger threshold, unsigned.
- `trig_rising`  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- `pretrig`  in  ADDR_W  number of samples stored before the trigger; range 0..N-1.
- `wr_en`  out  1  buffer write strobe.
- `wr_addr`  out  ADDR_W  buffer write address.
- `wr_data`  out  DATA_W  buffer write data.
- `trig_addr`  out  ADDR_W  buffer address of the trigger sample.
- `busy`  out  1  capture in progress (PRE, WAIT, POST).
- `done`  out  1  capture complete, buffer contents stable.

## Operation
- States:
  - IDLE: no writes.
  - PRE: fill pre-trigger samples.
  - WAIT: search for trigger.
  - POST: fill post-trigger samples.
  - DONE: hold.
- Arming:
  - `arm` in IDLE or DONE goes to PRE.
  - On arm: write pointer clears to 0, `prev_valid` clears, and `pretrig`, `trig_level` and `trig_rising` are latched.
  - `arm` in PRE, WAIT or POST is ignored.
- Sample writes:
  - Every accepted sample (`sample_valid`=1 in PRE, WAIT or POST) is written at the pointer.
  - The pointer then increments modulo N (wraps N-1 → 0).
- PRE: counts written samples. After `pretrig` writes it moves to WAIT. With `pretrig`=0 it moves to WAIT on the first cycle after arm.
- Trigger detection:
  - Active in WAIT only; the PRE→WAIT transition does not clear `prev`.
  - `prev` is the previous accepted sample; it is valid once one sample has been accepted since arm.
  - Rising trigger: `prev` < level AND `sample_in` >= level.
  - Falling trigger: `prev` >= level AND `sample_in` < level.
  - The first sample after arm can never trigger.
- On trigger:
  - The trigger sample is written.
  - `trig_addr` takes that sample's address.
  - The post counter loads N-1-`pretrig`.
  - Next state is POST, or DONE if the counter value is 0.
- POST: each accepted sample decrements the counter. The write that brings it to 0 moves the block to DONE.
- Buffer contents at DONE: oldest sample at (`trig_addr` − `pretrig`) mod N; the buffer holds exactly N valid samples.
- DONE: `done`=1, no writes. It holds until `arm` or `reset`.
- Reset mid-capture aborts. No partial `done` is reported.

## Timing
- All outputs are registered.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `trig_addr`=0, `busy`=0, `done`=0; state IDLE.
- Write latency: a sample accepted in cycle t appears as `wr_en`/`wr_addr`/`wr_data` in cycle t+1. `wr_en` is high for exactly one cycle per accepted sample.
- `busy` rises the cycle after `arm` and falls in the same cycle that `done` rises.
- `done` rises the cycle after the final `wr_en` pulse.
- `trig_addr` updates in the same cycle as the trigger sample's `wr_en`.
- `sample_valid` gaps stall all counters. There is no timeout.
- `arm` coincident with `sample_valid` in IDLE/DONE: that sample is not written.

## Structure
- Shared package: state encoding enum (IDLE, PRE, WAIT, POST, DONE) and a depth helper constant N = 1<<ADDR_W.
- One natural sub-module: `edge_detect`. It is combinational over `prev`, `sample_in`, level and polarity, and outputs the trigger hit.
- Write pointer, pre/post counters and FSM live in `trigger_capture`.

## Test plan
- Rising ramp: `pretrig`=4, level 0x80, ramp 0x00,0x10,… one sample per cycle → trigger on the 0x80 sample, `trig_addr`=8; 11 further writes ending at `wr_addr`=3; 20 writes total; then `done`.
- Falling edge: `pretrig`=0, level 0x80, samples 0xFF,0xFF,0x10,… → `trig_addr`=2; 15 post writes, last at address 1; `done`.
- Wrap with full pre-trigger: `pretrig`=15, 20×0x00 then 0x90 → `trig_addr`=4; no post writes; `done` the cycle after the trigger write.
- Threshold boundary, rising, level 0x80:
  - `prev`=0x7F, `sample_in`=0x80 → trigger.
  - `prev`=0x80, `sample_in`=0x80 → no trigger.
  - `sample_valid` gaps of 3 cycles → no extra `wr_en`, addresses contiguous.
- Control edge cases:
  - `arm` during WAIT → ignored.
  - `reset` mid-POST → next cycle all outputs at reset values, state IDLE; no writes until a new `arm`; re-arm from DONE restarts at address 0.
